// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Definitions shared by the pipeline valid/enable sequencer and its counters.
//   STG_IF..STG_WB : bit positions of each stage in a stage_vec_t
//   stage_vec_t    : packed per-stage vector (kill requests, valid bits)
//   CNT_W_DEFAULT  : default performance-counter width
// -----------------------------------------------------------------------------
package pipe_pkg;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int NUM_STG = 5;

  typedef logic [NUM_STG-1:0] stage_vec_t;

  localparam int CNT_W_DEFAULT = 32;

  // True when any stage receives a kill request this cycle.
  function automatic logic any_kill(input stage_vec_t kill);
    return |kill;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Event counter that increments by one per cycle with `inc` high and sticks at
// its all-ones value instead of wrapping.
//   clk   : clock
//   clr_n : asynchronous active-low clear
//   inc   : count this cycle
//   count : current value, W bits
// -----------------------------------------------------------------------------
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = CNT_W_DEFAULT
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = (count == {W{1'b1}});

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count <= '0;
    end else if (inc && !at_max) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_valid_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_valid_ctrl
// Turns the hazard unit's stall and kill requests into pipeline register load
// enables and per-stage valid bits for a 5-stage IF/ID/EX/MEM/WB pipeline.
// A low mem_ready freezes every register; kills still land during a freeze.
//
// Ports
//   clk                         : clock
//   reset                       : asynchronous active-low reset
//   stop_IF, stop_ID            : hold IF / hold ID and bubble EX
//   set_invalid_IF..WB          : kill the instruction in that stage
//   mem_ready                   : 0 freezes the whole pipeline
//   pc_en, ID_en..WB_en         : register load enables (combinational)
//   ID_invalid..WB_invalid      : inverted stage valid bits
//   retire                      : valid instruction leaves WB this cycle
//   retire_cnt/stall_cnt/flush_cnt : saturating event counters
// -----------------------------------------------------------------------------
module pipeline_valid_ctrl
  import pipe_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop_IF,
  input  logic             stop_ID,
  input  logic             set_invalid_IF,
  input  logic             set_invalid_ID,
  input  logic             set_invalid_EX,
  input  logic             set_invalid_MEM,
  input  logic             set_invalid_WB,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ID_en,
  output logic             EX_en,
  output logic             MEM_en,
  output logic             WB_en,
  output logic             ID_invalid,
  output logic             EX_invalid,
  output logic             MEM_invalid,
  output logic             WB_invalid,
  output logic             retire,
  output logic [CNT_W-1:0] retire_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic       adv;
  stage_vec_t kill;

  logic v_id,   v_ex,   v_mem,   v_wb;
  logic v_id_d, v_ex_d, v_mem_d, v_wb_d;

  logic stall_inc;
  logic flush_inc;

  assign adv = mem_ready;

  always_comb begin
    kill          = '0;
    kill[STG_IF]  = set_invalid_IF;
    kill[STG_ID]  = set_invalid_ID;
    kill[STG_EX]  = set_invalid_EX;
    kill[STG_MEM] = set_invalid_MEM;
    kill[STG_WB]  = set_invalid_WB;
  end

  // Enables are forced low while reset is held so no pipeline register loads
  // garbage during reset, even though the stage flops themselves are elsewhere.
  // NOTE: every output of a combinational block gets a default first so no
  // path through the block leaves it unassigned, which would infer a latch.
  always_comb begin
    pc_en  = 1'b0;
    ID_en  = 1'b0;
    EX_en  = 1'b0;
    MEM_en = 1'b0;
    WB_en  = 1'b0;
    if (reset && adv) begin
      pc_en  = ~stop_IF;
      ID_en  = ~stop_ID;
      EX_en  = 1'b1;
      MEM_en = 1'b1;
      WB_en  = 1'b1;
    end
  end

  // Default is the freeze behaviour: every stage keeps its instruction but a
  // kill request still clears its valid bit, so no kill is lost while stalled.
  always_comb begin
    v_id_d  = v_id  & ~kill[STG_ID];
    v_ex_d  = v_ex  & ~kill[STG_EX];
    v_mem_d = v_mem & ~kill[STG_MEM];
    v_wb_d  = v_wb  & ~kill[STG_WB];

    if (adv) begin
      v_wb_d  = v_mem & ~kill[STG_MEM];
      v_mem_d = v_ex  & ~kill[STG_EX];

      // A held ID stage sends a bubble into EX instead of its instruction.
      v_ex_d  = stop_ID ? 1'b0 : (v_id & ~kill[STG_ID]);

      if (stop_ID) begin
        v_id_d = v_id & ~kill[STG_ID];
      end else if (stop_IF) begin
        // ID advances but IF is held, so nothing new arrives behind it.
        v_id_d = 1'b0;
      end else begin
        // IF is always valid out of reset; only a kill stops it entering ID.
        v_id_d = ~kill[STG_IF];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_id  <= 1'b0;
      v_ex  <= 1'b0;
      v_mem <= 1'b0;
      v_wb  <= 1'b0;
    end else begin
      v_id  <= v_id_d;
      v_ex  <= v_ex_d;
      v_mem <= v_mem_d;
      v_wb  <= v_wb_d;
    end
  end

  assign ID_invalid  = ~v_id;
  assign EX_invalid  = ~v_ex;
  assign MEM_invalid = ~v_mem;
  assign WB_invalid  = ~v_wb;

  // v_wb is already 0 during reset, so retire needs no separate reset gating.
  assign retire = adv & v_wb & ~kill[STG_WB];

  assign stall_inc = ~adv | stop_IF | stop_ID;
  assign flush_inc = any_kill(kill);

  sat_counter #(.W(CNT_W)) u_retire_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (retire),
    .count (retire_cnt)
  );

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .clr_n (reset),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule
